// File: rtl/excp_ctrl.sv
// excp_ctrl: commit-point exception / interrupt / ERTN sequencer.
// Picks one winner among the stage exception reports, a pending interrupt and
// an ERTN. It waits for any in-flight CSR write to drain, pulses the CSR bus
// for one cycle and flushes the affected stages. It then holds a front-end
// redirect until the front end accepts it.
// Optional build macro: EXCP_CNT_EN adds per-kind commit counters.
module excp_ctrl #(
   parameter int PC_W      = 32,
   parameter int DRAIN_MAX = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req_valid,
   input  logic [23:0]       req_ecode,
   input  logic [35:0]       req_subecode,
   input  logic [4*PC_W-1:0] req_pc,
   input  logic [3:0]        req_badv_v,
   input  logic [4*PC_W-1:0] req_badv,
   input  logic              mem_valid,
   input  logic [PC_W-1:0]   mem_pc,
   input  logic              ertn_req,
   input  logic              have_intrpt,
   input  logic              csr_wr_busy,
   input  logic [PC_W-1:0]   csr_eentry,
   input  logic [PC_W-1:0]   csr_era,
   output logic              in_excp,
   output logic              is_etrn,
   output logic [5:0]        excp_ecode,
   output logic [8:0]        excp_subecode,
   output logic [PC_W-1:0]   excp_era,
   output logic              use_badv,
   output logic [PC_W-1:0]   bad_vaddr,
   output logic [3:0]        flush,
   output logic              stall,
   output logic              redirect_valid,
   output logic [PC_W-1:0]   redirect_pc,
   input  logic              redirect_ready,
   output logic              drain_timeout
`ifdef EXCP_CNT_EN
   ,
   output logic [31:0]       excp_cnt,
   output logic [31:0]       intr_cnt,
   output logic [31:0]       ertn_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAIN  = 2'd1,
      S_COMMIT = 2'd2,
      S_REDIR  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic [5:0]        ecode_q, ecode_d;
   logic [8:0]        sub_q, sub_d;
   logic [PC_W-1:0]   era_q, era_d;
   logic              badv_v_q, badv_v_d;
   logic [PC_W-1:0]   badv_q, badv_d;
   logic              ertn_q, ertn_d;
   logic              intr_q, intr_d;
   logic [1:0]        w_q, w_d;
   logic [PC_W-1:0]   rpc_q, rpc_d;

   // Winner candidate, evaluated every cycle; only captured in IDLE.
   logic              intr_ev_s;
   logic              event_s;
   logic [1:0]        sel_s;
   logic              sel_stage_s;
   logic [5:0]        win_ecode_s;
   logic [8:0]        win_sub_s;
   logic [PC_W-1:0]   win_pc_s;
   logic              win_badv_v_s;
   logic [PC_W-1:0]   win_badv_s;
   logic              win_ertn_s;
   logic              win_intr_s;
   logic [1:0]        win_w_s;

   assign intr_ev_s = have_intrpt & mem_valid;
   assign event_s   = intr_ev_s | (|req_valid) | ertn_req;

   // Fixed-priority arbitration: interrupt > MEM > ERTN > EXE > ID > IF.
   always_comb begin
      sel_s       = 2'd0;
      sel_stage_s = 1'b0;
      win_ertn_s  = 1'b0;
      win_intr_s  = 1'b0;
      win_w_s     = 2'd0;
      if (intr_ev_s) begin
         win_intr_s = 1'b1;
         win_w_s    = 2'd3;
      end else if (req_valid[3]) begin
         sel_s       = 2'd3;
         sel_stage_s = 1'b1;
         win_w_s     = 2'd3;
      end else if (ertn_req) begin
         win_ertn_s = 1'b1;
         win_w_s    = 2'd3;
      end else if (req_valid[2]) begin
         sel_s       = 2'd2;
         sel_stage_s = 1'b1;
         win_w_s     = 2'd2;
      end else if (req_valid[1]) begin
         sel_s       = 2'd1;
         sel_stage_s = 1'b1;
         win_w_s     = 2'd1;
      end else if (req_valid[0]) begin
         sel_s       = 2'd0;
         sel_stage_s = 1'b1;
         win_w_s     = 2'd0;
      end else begin
         sel_stage_s = 1'b0;
      end
   end

   // Build the winner record; ERTN and empty fields stay zero.
   always_comb begin
      win_ecode_s  = 6'd0;
      win_sub_s    = 9'd0;
      win_pc_s     = '0;
      win_badv_v_s = 1'b0;
      win_badv_s   = '0;
      if (win_intr_s) begin
         win_pc_s = mem_pc;
      end else if (sel_stage_s) begin
         win_ecode_s  = req_ecode[int'(sel_s)*6 +: 6];
         win_sub_s    = req_subecode[int'(sel_s)*9 +: 9];
         win_pc_s     = req_pc[int'(sel_s)*PC_W +: PC_W];
         win_badv_v_s = req_badv_v[sel_s];
         win_badv_s   = req_badv[int'(sel_s)*PC_W +: PC_W];
      end else begin
         win_pc_s = '0;
      end
   end

   // Sequencer next-state: capture in IDLE, drain CSR writes, commit, redirect.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      ecode_d   = ecode_q;
      sub_d     = sub_q;
      era_d     = era_q;
      badv_v_d  = badv_v_q;
      badv_d    = badv_q;
      ertn_d    = ertn_q;
      intr_d    = intr_q;
      w_d       = w_q;
      rpc_d     = rpc_q;
      case (state_q)
         S_IDLE: begin
            if (event_s) begin
               ecode_d  = win_ecode_s;
               sub_d    = win_sub_s;
               era_d    = win_pc_s;
               badv_v_d = win_badv_v_s;
               badv_d   = win_badv_s;
               ertn_d   = win_ertn_s;
               intr_d   = win_intr_s;
               w_d      = win_w_s;
               cnt_d    = 8'd0;
               state_d  = S_DRAIN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (!csr_wr_busy) begin
               state_d = S_COMMIT;
            end else if (cnt_q == 8'(DRAIN_MAX)) begin
               timeout_d = 1'b1;
               state_d   = S_COMMIT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_COMMIT: begin
            rpc_d   = ertn_q ? csr_era : csr_eentry;
            state_d = S_REDIR;
         end
         S_REDIR: begin
            if (redirect_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_REDIR;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and record registers; reset clears everything including the sticky timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
         ecode_q   <= 6'd0;
         sub_q     <= 9'd0;
         era_q     <= '0;
         badv_v_q  <= 1'b0;
         badv_q    <= '0;
         ertn_q    <= 1'b0;
         intr_q    <= 1'b0;
         w_q       <= 2'd0;
         rpc_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         ecode_q   <= ecode_d;
         sub_q     <= sub_d;
         era_q     <= era_d;
         badv_v_q  <= badv_v_d;
         badv_q    <= badv_d;
         ertn_q    <= ertn_d;
         intr_q    <= intr_d;
         w_q       <= w_d;
         rpc_q     <= rpc_d;
      end
   end

   // Flush every stage at or younger-than the winner, only during COMMIT.
   always_comb begin
      flush = 4'b0000;
      if (state_q == S_COMMIT) begin
         case (w_q)
            2'd0:    flush = 4'b0001;
            2'd1:    flush = 4'b0011;
            2'd2:    flush = 4'b0111;
            2'd3:    flush = 4'b1111;
            default: flush = 4'b1111;
         endcase
      end else begin
         flush = 4'b0000;
      end
   end

   assign in_excp        = (state_q == S_COMMIT) & ~ertn_q;
   assign is_etrn        = (state_q == S_COMMIT) &  ertn_q;
   assign use_badv       = (state_q == S_COMMIT) &  badv_v_q;
   assign excp_ecode     = ecode_q;
   assign excp_subecode  = sub_q;
   assign excp_era       = era_q;
   assign bad_vaddr      = badv_q;
   assign stall          = (state_q != S_IDLE) | event_s;
   assign redirect_valid = (state_q == S_REDIR);
   assign redirect_pc    = rpc_q;
   assign drain_timeout  = timeout_q;

`ifdef EXCP_CNT_EN
   logic [31:0] excp_cnt_q, intr_cnt_q, ertn_cnt_q;

   // Per-kind commit counters, wrapping naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         excp_cnt_q <= 32'd0;
         intr_cnt_q <= 32'd0;
         ertn_cnt_q <= 32'd0;
      end else if (state_q == S_COMMIT) begin
         if (ertn_q) begin
            ertn_cnt_q <= ertn_cnt_q + 32'd1;
         end else if (intr_q) begin
            intr_cnt_q <= intr_cnt_q + 32'd1;
         end else begin
            excp_cnt_q <= excp_cnt_q + 32'd1;
         end
      end
   end

   assign excp_cnt = excp_cnt_q;
   assign intr_cnt = intr_cnt_q;
   assign ertn_cnt = ertn_cnt_q;
`endif

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed self-checking bench for excp_ctrl.
module tb_excp_ctrl;

   localparam int PC_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        req_valid;
   logic [23:0]       req_ecode;
   logic [35:0]       req_subecode;
   logic [4*PC_W-1:0] req_pc;
   logic [3:0]        req_badv_v;
   logic [4*PC_W-1:0] req_badv;
   logic              mem_valid;
   logic [PC_W-1:0]   mem_pc;
   logic              ertn_req;
   logic              have_intrpt;
   logic              csr_wr_busy;
   logic [PC_W-1:0]   csr_eentry;
   logic [PC_W-1:0]   csr_era;
   logic              in_excp;
   logic              is_etrn;
   logic [5:0]        excp_ecode;
   logic [8:0]        excp_subecode;
   logic [PC_W-1:0]   excp_era;
   logic              use_badv;
   logic [PC_W-1:0]   bad_vaddr;
   logic [3:0]        flush;
   logic              stall;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              redirect_ready;
   logic              drain_timeout;
`ifdef EXCP_CNT_EN
   logic [31:0]       excp_cnt, intr_cnt, ertn_cnt;
`endif

   int vectors = 0;
   int errors  = 0;

   excp_ctrl #(.PC_W(PC_W), .DRAIN_MAX(7)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ecode(req_ecode), .req_subecode(req_subecode),
      .req_pc(req_pc), .req_badv_v(req_badv_v), .req_badv(req_badv),
      .mem_valid(mem_valid), .mem_pc(mem_pc), .ertn_req(ertn_req),
      .have_intrpt(have_intrpt), .csr_wr_busy(csr_wr_busy),
      .csr_eentry(csr_eentry), .csr_era(csr_era),
      .in_excp(in_excp), .is_etrn(is_etrn), .excp_ecode(excp_ecode),
      .excp_subecode(excp_subecode), .excp_era(excp_era), .use_badv(use_badv),
      .bad_vaddr(bad_vaddr), .flush(flush), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_ready(redirect_ready), .drain_timeout(drain_timeout)
`ifdef EXCP_CNT_EN
      , .excp_cnt(excp_cnt), .intr_cnt(intr_cnt), .ertn_cnt(ertn_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = 4'd0; req_ecode = 24'd0; req_subecode = 36'd0;
      req_pc = '0; req_badv_v = 4'd0; req_badv = '0;
      mem_valid = 1'b0; mem_pc = '0; ertn_req = 1'b0; have_intrpt = 1'b0;
      csr_wr_busy = 1'b0; redirect_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      csr_eentry = 32'h0; csr_era = 32'h0;
      tick(); tick();
      vectors++;
      if ({in_excp, is_etrn, use_badv, stall, redirect_valid, drain_timeout, flush} !== 10'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 0", {in_excp, is_etrn, use_badv, stall, redirect_valid, drain_timeout, flush});
      end
      vectors++;
      if ({excp_ecode, excp_subecode, excp_era, bad_vaddr, redirect_pc} !== 111'd0) begin
         errors++;
         $display("FAIL reset_data got %h exp 0", {excp_ecode, excp_subecode, excp_era, bad_vaddr, redirect_pc});
      end
      rst = 1'b0;
      tick();
   endtask

   // EXE exception, no CSR write pending.
   task automatic test_exe_excp();
      req_valid = 4'b0100;
      req_ecode[17:12] = 6'h0B;
      req_pc[95:64] = 32'h1C00_0010;
      csr_eentry = 32'h1C00_8000;
      #1;
      vectors++;
      if (stall !== 1'b1 || in_excp !== 1'b0) begin
         errors++; $display("FAIL exe_idle_stall got stall=%b in_excp=%b exp 1/0", stall, in_excp);
      end
      tick();
      clear_inputs();
      vectors++;
      if (in_excp !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("FAIL exe_drain got in_excp=%b stall=%b exp 0/1", in_excp, stall);
      end
      tick();
      vectors++;
      if ({in_excp, is_etrn, flush, use_badv} !== 7'b1001110) begin
         errors++; $display("FAIL exe_commit_ctrl got %b exp 1001110", {in_excp, is_etrn, flush, use_badv});
      end
      vectors++;
      if (excp_ecode !== 6'h0B || excp_era !== 32'h1C00_0010) begin
         errors++; $display("FAIL exe_commit_rec got ecode=%h era=%h exp 0b/1c000010", excp_ecode, excp_era);
      end
      tick();
      csr_eentry = 32'h1C00_9999;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_8000 || in_excp !== 1'b0 || flush !== 4'd0) begin
            errors++; $display("FAIL exe_redir_hold got v=%b pc=%h in_excp=%b flush=%b exp 1/1c008000/0/0",
                               redirect_valid, redirect_pc, in_excp, flush);
         end
         tick();
      end
      redirect_ready = 1'b1;
      #1;
      vectors++;
      if (redirect_valid !== 1'b1) begin
         errors++; $display("FAIL exe_redir_handshake got %b exp 1", redirect_valid);
      end
      tick();
      redirect_ready = 1'b0;
      vectors++;
      if (redirect_valid !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL exe_back_idle got v=%b stall=%b exp 0/0", redirect_valid, stall);
      end
   endtask

   // Interrupt and MEM exception together: the interrupt wins.
   task automatic test_interrupt();
      have_intrpt = 1'b1; mem_valid = 1'b1; mem_pc = 32'h1C00_0100;
      req_valid = 4'b1000; req_ecode[23:18] = 6'h08;
      req_pc[127:96] = 32'h1C00_0555;
      req_badv_v = 4'b1000; req_badv[127:96] = 32'hDEAD_BEEF;
      tick();
      clear_inputs();
      tick();
      vectors++;
      if ({in_excp, is_etrn, flush, use_badv} !== 7'b1011110) begin
         errors++; $display("FAIL intr_commit_ctrl got %b exp 1011110", {in_excp, is_etrn, flush, use_badv});
      end
      vectors++;
      if (excp_ecode !== 6'h00 || excp_subecode !== 9'd0 || excp_era !== 32'h1C00_0100) begin
         errors++; $display("FAIL intr_commit_rec got ecode=%h sub=%h era=%h exp 0/0/1c000100",
                            excp_ecode, excp_subecode, excp_era);
      end
      redirect_ready = 1'b1;
      tick(); tick();
      redirect_ready = 1'b0;
   endtask

   // ERTN with CSR busy during the event cycle and the next two cycles.
   task automatic test_ertn_drain();
      ertn_req = 1'b1; csr_era = 32'h1C00_0200; csr_wr_busy = 1'b1;
      tick();
      ertn_req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) csr_wr_busy = 1'b0;
         vectors++;
         if (in_excp !== 1'b0 || is_etrn !== 1'b0) begin
            errors++; $display("FAIL ertn_wait cycle %0d got in_excp=%b is_etrn=%b exp 0/0", i, in_excp, is_etrn);
         end
         tick();
      end
      vectors++;
      if ({in_excp, is_etrn, flush, drain_timeout} !== 7'b0111110) begin
         errors++; $display("FAIL ertn_commit got %b exp 0111110", {in_excp, is_etrn, flush, drain_timeout});
      end
      tick();
      vectors++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C00_0200) begin
         errors++; $display("FAIL ertn_redir got v=%b pc=%h exp 1/1c000200", redirect_valid, redirect_pc);
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
   endtask

   // CSR busy stuck: eight DRAIN cycles, then forced COMMIT and sticky timeout.
   task automatic test_timeout();
      req_valid = 4'b0010; req_ecode[11:6] = 6'h0D; csr_wr_busy = 1'b1;
      tick();
      req_valid = 4'b0000;
      for (int i = 1; i <= 8; i++) begin
         vectors++;
         if (in_excp !== 1'b0 || drain_timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_wait cycle %0d got in_excp=%b tmo=%b exp 0/0", i, in_excp, drain_timeout);
         end
         tick();
      end
      vectors++;
      if ({in_excp, flush, drain_timeout} !== 6'b100111) begin
         errors++; $display("FAIL tmo_commit got %b exp 100111", {in_excp, flush, drain_timeout});
      end
      csr_wr_busy = 1'b0; redirect_ready = 1'b1;
      tick(); tick();
      redirect_ready = 1'b0;
      tick();
      vectors++;
      if (drain_timeout !== 1'b1 || stall !== 1'b0) begin
         errors++; $display("FAIL tmo_sticky got tmo=%b stall=%b exp 1/0", drain_timeout, stall);
      end
   endtask

   // Events during the sequence are ignored; the IF winner keeps its flush.
   task automatic test_back_to_back();
      req_valid = 4'b0001; req_ecode[5:0] = 6'h03;
      tick();
      req_valid = 4'b1000; req_ecode[23:18] = 6'h11;
      tick();
      vectors++;
      if (in_excp !== 1'b1 || flush !== 4'b0001 || excp_ecode !== 6'h03) begin
         errors++; $display("FAIL b2b_commit got in_excp=%b flush=%b ecode=%h exp 1/0001/03", in_excp, flush, excp_ecode);
      end
      clear_inputs();
      redirect_ready = 1'b1;
      tick(); tick();
      redirect_ready = 1'b0;
   endtask

   // ADEF at IF with BADV, then asynchronous reset while redirecting.
   task automatic test_badv_async_reset();
      req_valid = 4'b0001; req_ecode[5:0] = 6'h08; req_subecode[8:0] = 9'h000;
      req_pc[31:0] = 32'h1C00_0003; req_badv_v = 4'b0001; req_badv[31:0] = 32'h1C00_0003;
      tick();
      clear_inputs();
      vectors++;
      if (use_badv !== 1'b0) begin
         errors++; $display("FAIL badv_drain got %b exp 0", use_badv);
      end
      tick();
      vectors++;
      if (use_badv !== 1'b1 || bad_vaddr !== 32'h1C00_0003 || flush !== 4'b0001) begin
         errors++; $display("FAIL badv_commit got use=%b va=%h flush=%b exp 1/1c000003/0001", use_badv, bad_vaddr, flush);
      end
      tick();
      vectors++;
      if (use_badv !== 1'b0 || redirect_valid !== 1'b1) begin
         errors++; $display("FAIL badv_redir got use=%b v=%b exp 0/1", use_badv, redirect_valid);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({redirect_valid, stall, drain_timeout, in_excp, use_badv} !== 5'd0 ||
          {excp_ecode, bad_vaddr, redirect_pc, excp_era} !== 102'd0) begin
         errors++; $display("FAIL async_reset got ctl=%b data=%h exp 0/0",
                            {redirect_valid, stall, drain_timeout, in_excp, use_badv},
                            {excp_ecode, bad_vaddr, redirect_pc, excp_era});
      end
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (redirect_valid !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got v=%b stall=%b exp 0/0", redirect_valid, stall);
      end
   endtask

`ifdef EXCP_CNT_EN
   // Run one full sequence of the given kind: 0 exception, 1 interrupt, 2 ERTN.
   task automatic run_seq(input int kind);
      int n;
      if (kind == 0) req_valid = 4'b0100;
      else if (kind == 1) begin have_intrpt = 1'b1; mem_valid = 1'b1; end
      else ertn_req = 1'b1;
      tick();
      clear_inputs();
      n = 0;
      while (!(in_excp || is_etrn) && n < 20) begin tick(); n++; end
      if (n >= 20) begin
         vectors++; errors++; $display("FAIL cnt_seq_commit timeout kind %0d", kind);
      end
      redirect_ready = 1'b1;
      n = 0;
      tick();
      while (redirect_valid && n < 20) begin tick(); n++; end
      redirect_ready = 1'b0;
   endtask

   task automatic test_counters();
      run_seq(0); run_seq(1); run_seq(0); run_seq(2); run_seq(0); run_seq(2);
      vectors++;
      if (excp_cnt !== 32'd3 || intr_cnt !== 32'd1 || ertn_cnt !== 32'd2) begin
         errors++; $display("FAIL counters got %0d/%0d/%0d exp 3/1/2", excp_cnt, intr_cnt, ertn_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exe_excp();
      test_interrupt();
      test_ertn_drain();
      test_timeout();
      test_back_to_back();
      test_badv_async_reset();
`ifdef EXCP_CNT_EN
      test_counters();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
